// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter
//   Round-robin arbiter for 2**N requesters. It gives a registered one-hot
//   grant together with the matching binary index. A grant stays with its
//   owner until one of these happens: the owner pulses done, the owner drops
//   its request, or the hold timeout runs out. On a release the next winner
//   takes over at the same edge, so no bubble cycle is inserted.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req          [2**N] level-sensitive request vector
//   done         current owner releases this cycle (ignored when idle)
//   grant_onehot [2**N] one-hot grant, all zeros when no grant is active
//   grant_idx    [N]    binary index of the owner (valid with grant_valid)
//   grant_valid         a grant is active
//   timeout             one-cycle pulse after a release forced by the timeout
module rr_onehot_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2**N-1:0] req,
  input  logic            done,
  output logic [2**N-1:0] grant_onehot,
  output logic [N-1:0]    grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  localparam int NR = 2**N;
  // hold_cnt only needs to count 0..MAX_HOLD-1
  localparam int             CW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0]  HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic           TO_EN     = (MAX_HOLD != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_n;
  logic [N-1:0]   last_idx, last_n;
  logic [CW-1:0]  hold_cnt, cnt_n;
  logic [NR-1:0]  oh_n;
  logic [N-1:0]   idx_n;
  logic           vld_n, to_n;

  // The search pointer is the previous owner. While busy, that is the
  // current owner: on a release, last_idx picks up grant_idx at the same
  // edge, so the search has to start from the new value already.
  logic [N-1:0]   base, win;
  logic           found;

  assign base = (state == BUSY) ? grant_idx : last_idx;

  // Rotating priority: base+1 comes first and base itself comes last (wrap
  // is implicit in N-bit arithmetic). The previous owner therefore wins only
  // when it is the sole requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int o = 1; o <= NR; o++) begin
      if (!found && req[N'(base + N'(o))]) begin
        found = 1'b1;
        win   = N'(base + N'(o));
      end
    end
  end

  logic rel_drop, rel_exp, rel;
  assign rel_drop = ~req[grant_idx];
  assign rel_exp  = TO_EN & (hold_cnt == HOLD_LAST);
  assign rel      = done | rel_drop | rel_exp;

  always_comb begin
    state_n = state;
    last_n  = last_idx;
    cnt_n   = hold_cnt;
    idx_n   = grant_idx;
    oh_n    = grant_onehot;
    vld_n   = grant_valid;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          idx_n   = win;
          oh_n    = {{(NR-1){1'b0}}, 1'b1} << win;
          vld_n   = 1'b1;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (rel) begin
          last_n = grant_idx;
          // Timeout is flagged only when expiry is the sole release cause.
          to_n   = rel_exp & ~done & ~rel_drop;
          if (found) begin
            idx_n = win;
            oh_n  = {{(NR-1){1'b0}}, 1'b1} << win;
            cnt_n = '0;
          end else begin
            // grant_idx keeps its stale value while idle
            state_n = IDLE;
            vld_n   = 1'b0;
            oh_n    = '0;
          end
        end else begin
          cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_idx     <= '1;   // first search begins at requester 0
      hold_cnt     <= '0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      grant_valid  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      last_idx     <= last_n;
      hold_cnt     <= cnt_n;
      grant_idx    <= idx_n;
      grant_onehot <= oh_n;
      grant_valid  <= vld_n;
      timeout      <= to_n;
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
module tb_rr_onehot_arbiter;

  localparam int N        = 2;
  localparam int NR       = 4;
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic          done = 1'b0;
  logic [NR-1:0] grant_onehot;
  logic [N-1:0]  grant_idx;
  logic          grant_valid;
  logic          timeout;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int m_valid, m_idx, m_last, m_cnt, m_to;

  rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant_onehot(grant_onehot), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // first requester strictly after 'prev' going upward with wrap, -1 if none
  function automatic int find(input int prev, input logic [NR-1:0] q);
    for (int o = 1; o <= NR; o++) begin
      if (q[(prev + o) % NR]) return (prev + o) % NR;
    end
    return -1;
  endfunction

  task automatic model(input logic r, input logic [NR-1:0] q, input logic d);
    int w;
    if (r) begin
      m_valid = 0; m_idx = 0; m_last = NR - 1; m_cnt = 0; m_to = 0;
    end else if (m_valid == 0) begin
      m_to = 0;
      w = find(m_last, q);
      if (w >= 0) begin m_valid = 1; m_idx = w; m_cnt = 0; end
    end else begin
      bit by_done, by_drop, by_exp;
      by_done = d;
      by_drop = !q[m_idx];
      by_exp  = (MAX_HOLD != 0) && (m_cnt == MAX_HOLD - 1);
      m_to = 0;
      if (by_done || by_drop || by_exp) begin
        m_to   = (by_exp && !by_done && !by_drop) ? 1 : 0;
        m_last = m_idx;
        w = find(m_idx, q);
        if (w >= 0) begin m_idx = w; m_cnt = 0; end
        else m_valid = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic r, input logic [NR-1:0] q, input logic d);
    logic [NR-1:0] exp_oh;
    @(negedge clk);
    rst = r; req = q; done = d;
    @(posedge clk);
    model(r, q, d);
    #1;
    exp_oh = m_valid ? NR'(1 << m_idx) : '0;
    chk("grant_valid",  32'(grant_valid),  32'(m_valid));
    chk("grant_onehot", 32'(grant_onehot), 32'(exp_oh));
    chk("grant_idx",    32'(grant_idx),    32'(m_idx));
    chk("timeout",      32'(timeout),      32'(m_to));
  endtask

  initial begin
    logic [NR-1:0] q;
    logic d, r;

    // reset state
    step(1'b1, 4'b0000, 1'b0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_oh",    32'(grant_onehot), 32'd0);
    chk("rst_to",    32'(timeout), 32'd0);

    // first grant after reset
    step(1'b0, 4'b1010, 1'b0);
    chk("first_idx", 32'(grant_idx), 32'd1);
    chk("first_oh",  32'(grant_onehot), 32'h2);

    // rotation with all requesting, done at every grant: 0,1,2,3,0
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    chk("rot_idx0", 32'(grant_idx), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 4'b1111, 1'b1);
      chk("rot_idx",   32'(grant_idx), 32'(k % NR));
      chk("rot_oh",    32'(grant_onehot), 32'(1 << (k % NR)));
      chk("rot_valid", 32'(grant_valid), 32'd1);
    end

    // wrap to owner 3, then sole requester 3 is re-granted
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    chk("own3", 32'(grant_idx), 32'd3);
    step(1'b0, 4'b1000, 1'b1);
    chk("sole_idx",   32'(grant_idx), 32'd3);
    chk("sole_valid", 32'(grant_valid), 32'd1);
    step(1'b0, 4'b0000, 1'b1);
    chk("idle_valid", 32'(grant_valid), 32'd0);
    chk("idle_oh",    32'(grant_onehot), 32'd0);

    // timeout: owner 2 holds, released on 4th busy edge
    step(1'b0, 4'b0100, 1'b0);
    chk("to_own2", 32'(grant_idx), 32'd2);
    for (int k = 0; k < 3; k++) step(1'b0, 4'b1100, 1'b0);
    chk("to_hold", 32'(grant_idx), 32'd2);
    step(1'b0, 4'b1100, 1'b0);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_next",  32'(grant_idx), 32'd3);
    step(1'b0, 4'b1000, 1'b0);
    chk("to_once", 32'(timeout), 32'd0);

    // done coinciding with expiry: no timeout
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0100, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 4'b1100, 1'b0);
    step(1'b0, 4'b1100, 1'b1);
    chk("todone_to",  32'(timeout), 32'd0);
    chk("todone_idx", 32'(grant_idx), 32'd3);

    // owner drop: owner 1 withdraws, 0 pending
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0010, 1'b0);
    chk("drop_own1", 32'(grant_idx), 32'd1);
    step(1'b0, 4'b0001, 1'b0);
    chk("drop_oh", 32'(grant_onehot), 32'h1);
    chk("drop_to", 32'(timeout), 32'd0);

    // reset mid-grant
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0100, 1'b0);
    chk("mid_own2", 32'(grant_idx), 32'd2);
    step(1'b1, 4'b0100, 1'b0);
    chk("mid_valid", 32'(grant_valid), 32'd0);
    chk("mid_idx",   32'(grant_idx), 32'd0);
    step(1'b0, 4'b0101, 1'b0);
    chk("mid_first", 32'(grant_idx), 32'd0);

    // randomized traffic against the model
    q = 4'b1111;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 63) == 0);
      step(r, q, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
